vga_test: RTL and testbench
===========================

VGA_TEST -- requirements
Module: vga_test

Interface
REQ-001 SHALL have port MAX10_CLK1_50, input, 1 bit: the single 50 MHz system clock, which is also the pixel clock; all logic is on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port VGA_R, output, 4 bits: red level.
REQ-004 SHALL have port VGA_G, output, 4 bits: green level.
REQ-005 SHALL have port VGA_B, output, 4 bits: blue level.
REQ-006 SHALL have port VGA_HS, output, 1 bit: horizontal sync, active-high.
REQ-007 SHALL have port VGA_VS, output, 1 bit: vertical sync, active-high.
REQ-008 SHALL have no parameters; the timing below is fixed.

Function
REQ-009 SHALL generate 800x600 at 72 Hz timing with one pixel per clock (50 MHz).
REQ-010 SHALL keep an 11-bit horizontal counter h_cnt that counts 0..1039 and wraps to 0.
REQ-011 SHALL keep a 10-bit vertical counter v_cnt that increments only when h_cnt wraps 1039->0, counts 0..665, and wraps to 0 after line 665.
REQ-012 SHALL use horizontal timing: visible 0..799, front porch 800..855, sync 856..975 (120 clocks), back porch 976..1039.
REQ-013 SHALL use vertical timing: visible 0..599, front porch 600..636, sync 637..642 (6 lines), back porch 643..665.
REQ-014 SHALL make one frame exactly 1040 x 666 = 692,640 clocks (13,852,800 ns).
REQ-015 SHALL register all outputs, so each output reflects the counter values of the previous clock (latency 1 clock).
REQ-016 SHALL set VGA_HS to 1 iff 856 <= h_cnt <= 975.
REQ-017 SHALL set VGA_VS to 1 iff 637 <= v_cnt <= 642, independent of h_cnt.
REQ-018 SHALL force VGA_R, VGA_G and VGA_B to 0 whenever h_cnt >= 800 or v_cnt >= 600 (blanking).
REQ-019 SHALL draw 8 vertical colour bars, each 100 px wide, in rows 0..299. Colour index = h_cnt/100, in order: white, yellow, cyan, green, magenta, red, blue, black. Each primary component is either 4'hF or 4'h0 (for example, yellow is R=F, G=F, B=0).
REQ-020 SHALL draw a grey ramp in rows 300..599: R = G = B = h_cnt/50, giving 16 steps of 50 px each with values 0..15. Integer division SHALL be realised with comparators, not a divider.
REQ-021 SHALL require no input stimulus other than clock and reset; the pattern is static across frames.

Reset
REQ-022 SHALL, while reset = 1 at a rising edge, clear h_cnt and v_cnt to 0 and clear VGA_R, VGA_G, VGA_B, VGA_HS and VGA_VS to 0.
REQ-023 SHALL, on the first clock after reset is released, present pixel (0,0) on the outputs (white, syncs 0), and counting proceeds from 0.
REQ-024 SHALL apply reset asserted mid-frame identically to reset at start-up; no partial-frame state is retained.
REQ-025 SHALL start the counters at 0 with the output registers at 0 at power-up, so operation is correct without any reset being applied.

Verification
REQ-026 SHALL cover reset: hold reset high for 5 clocks, then check all outputs = 0; release reset, and one clock later check R=G=B=F, HS=0, VS=0.
REQ-027 SHALL cover horizontal timing: the HS rising-edge period is 1040 clocks, and each HS high pulse lasts exactly 120 clocks, starting 857 clocks after the first post-reset clock.
REQ-028 SHALL cover vertical timing: each VS high pulse lasts 6240 clocks, and consecutive VS rising edges are 692,640 clocks apart (one frame).
REQ-029 SHALL cover colour bars at these sampled pixels (x,y):
- (150,10) gives F/F/0.
- (450,10) gives F/0/F.
- (750,10) gives 0/0/0.
- (99,299) gives F/F/F.
- (100,299) gives F/F/0.
REQ-030 SHALL cover the ramp and blanking at these sampled pixels:
- (120,400) gives R=G=B=2.
- (799,599) gives 15.
- (800,0) gives 0.
- (0,600) gives 0.
- Throughout the VS pulse, RGB is always 0.
REQ-031 SHALL cover mid-frame reset: assert reset at line 300, pixel 500; after release, the outputs follow the pixel (0,0) sequence, and the next VS rises 637 x 1040 + 1 clocks later.

Source files
------------

// File: rtl/vga_test.sv
// vga_test: fixed 800x600 @ 72 Hz colour-bar / grey-ramp pattern generator.
// One pixel per 50 MHz clock. Outputs are registered, so they show the
// pixel addressed by the counters on the previous clock.
module vga_test (
   input  logic       MAX10_CLK1_50,
   input  logic       reset,
   output logic [3:0] VGA_R,
   output logic [3:0] VGA_G,
   output logic [3:0] VGA_B,
   output logic       VGA_HS,
   output logic       VGA_VS
);

   // Horizontal timing (pixels)
   localparam logic [10:0] H_VIS      = 11'd800;
   localparam logic [10:0] H_SYNC_BEG = 11'd856;
   localparam logic [10:0] H_SYNC_END = 11'd975;
   localparam logic [10:0] H_LAST     = 11'd1039;

   // Vertical timing (lines)
   localparam logic [9:0]  V_BAR_END  = 10'd300;
   localparam logic [9:0]  V_VIS      = 10'd600;
   localparam logic [9:0]  V_SYNC_BEG = 10'd637;
   localparam logic [9:0]  V_SYNC_END = 10'd642;
   localparam logic [9:0]  V_LAST     = 10'd665;

   // Declaration initialisers give a working power-up state without reset.
   logic [10:0] r_h_cnt = '0;
   logic [9:0]  r_v_cnt = '0;
   logic [3:0]  r_red   = '0;
   logic [3:0]  r_green = '0;
   logic [3:0]  r_blue  = '0;
   logic        r_hs    = 1'b0;
   logic        r_vs    = 1'b0;

   logic        w_h_wrap;
   logic        w_v_wrap;
   logic        w_active;
   logic        w_hs;
   logic        w_vs;
   logic [2:0]  w_bar_idx;
   logic [3:0]  w_ramp;
   logic        w_bar_r;
   logic        w_bar_g;
   logic        w_bar_b;
   logic [3:0]  w_r;
   logic [3:0]  w_g;
   logic [3:0]  w_b;

   assign w_h_wrap = (r_h_cnt == H_LAST);
   assign w_v_wrap = (r_v_cnt == V_LAST);
   assign w_active = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
   assign w_hs     = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt <= H_SYNC_END);
   assign w_vs     = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt <= V_SYNC_END);

   // Pixel and line counters; the line counter advances on the pixel wrap only.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (reset) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_h_wrap) begin
         r_h_cnt <= '0;
         if (w_v_wrap) begin
            r_v_cnt <= '0;
         end else begin
            r_v_cnt <= r_v_cnt + 10'd1;
         end
      end else begin
         r_h_cnt <= r_h_cnt + 11'd1;
      end
   end

   // Bar index = h_cnt/100 built from threshold compares (saturates at 7 past 700).
   always_comb begin
      w_bar_idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (r_h_cnt >= 11'(i * 100)) begin
            w_bar_idx = 3'(i);
         end
      end
   end

   // Ramp level = h_cnt/50 built from threshold compares (saturates at 15 past 750).
   always_comb begin
      w_ramp = 4'd0;
      for (int i = 1; i < 16; i++) begin
         if (r_h_cnt >= 11'(i * 50)) begin
            w_ramp = 4'(i);
         end
      end
   end

   // Bar palette: white, yellow, cyan, green, magenta, red, blue, black.
   always_comb begin
      w_bar_r = 1'b0;
      w_bar_g = 1'b0;
      w_bar_b = 1'b0;
      case (w_bar_idx)
         3'd0:    begin w_bar_r = 1'b1; w_bar_g = 1'b1; w_bar_b = 1'b1; end
         3'd1:    begin w_bar_r = 1'b1; w_bar_g = 1'b1; end
         3'd2:    begin w_bar_g = 1'b1; w_bar_b = 1'b1; end
         3'd3:    begin w_bar_g = 1'b1; end
         3'd4:    begin w_bar_r = 1'b1; w_bar_b = 1'b1; end
         3'd5:    begin w_bar_r = 1'b1; end
         3'd6:    begin w_bar_b = 1'b1; end
         default: begin end
      endcase
   end

   // Select bars (top half), ramp (bottom half) or black during blanking.
   always_comb begin
      w_r = 4'h0;
      w_g = 4'h0;
      w_b = 4'h0;
      if (w_active) begin
         if (r_v_cnt < V_BAR_END) begin
            w_r = {4{w_bar_r}};
            w_g = {4{w_bar_g}};
            w_b = {4{w_bar_b}};
         end else begin
            w_r = w_ramp;
            w_g = w_ramp;
            w_b = w_ramp;
         end
      end
   end

   // Output registers: one clock behind the counters.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (reset) begin
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
         r_hs    <= 1'b0;
         r_vs    <= 1'b0;
      end else begin
         r_red   <= w_r;
         r_green <= w_g;
         r_blue  <= w_b;
         r_hs    <= w_hs;
         r_vs    <= w_vs;
      end
   end

   assign VGA_R  = r_red;
   assign VGA_G  = r_green;
   assign VGA_B  = r_blue;
   assign VGA_HS = r_hs;
   assign VGA_VS = r_vs;

endmodule

// File: tb/tb_vga_test.sv
// tb_vga_test: checks vga_test against a frame-position model, plus literal
// spot pixels, sync pulse timing and mid-frame reset behaviour.
module tb_vga_test;

   localparam int H_TOT = 1040;
   localparam int V_TOT = 666;
   localparam int FRAME = H_TOT * V_TOT;
   localparam logic [2:0] BARS [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                       3'b101, 3'b100, 3'b001, 3'b000};

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] vr, vg, vb;
   logic       hs, vs;

   vga_test dut (
      .MAX10_CLK1_50(clk),
      .reset        (rst),
      .VGA_R        (vr),
      .VGA_G        (vg),
      .VGA_B        (vb),
      .VGA_HS       (hs),
      .VGA_VS       (vs)
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
   endtask

   // Expected {R,G,B,HS,VS} for the pixel at linear frame position pos.
   function automatic int expect_px(input int pos);
      int x, y;
      logic [3:0] rr, gg, bb;
      logic [2:0] bar;
      logic h, v;
      x = pos % H_TOT;
      y = pos / H_TOT;
      rr = 4'h0; gg = 4'h0; bb = 4'h0;
      if (x < 800 && y < 600) begin
         if (y < 300) begin
            bar = BARS[x / 100];
            rr = bar[2] ? 4'hF : 4'h0;
            gg = bar[1] ? 4'hF : 4'h0;
            bb = bar[0] ? 4'hF : 4'h0;
         end else begin
            rr = 4'(x / 50);
            gg = rr;
            bb = rr;
         end
      end
      h = (x >= 856 && x <= 975);
      v = (y >= 637 && y <= 642);
      return 32'({rr, gg, bb, h, v});
   endfunction

   // Model: m_pos is the position the design is about to address; m_shown is
   // the position whose pixel is on the outputs after this edge.
   bit m_valid = 1'b0;
   int m_pos   = 0;
   int m_shown = 0;
   int rel     = 0;     // rising edges since reset release (or power-up)
   int hs_rise = -1;
   int vs_rise = -1;

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1'b0;
         m_pos   = 0;
         rel     = 0;
         hs_rise = -1;
         vs_rise = -1;
      end else begin
         m_shown = m_pos;
         m_valid = 1'b1;
         m_pos   = (m_pos + 1) % FRAME;
         rel++;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      int exp_v, act_v;
      exp_v = m_valid ? expect_px(m_shown) : 0;
      act_v = 32'({vr, vg, vb, hs, vs});
      n_checks++;
      if (act_v == exp_v) n_pass++;
      else $display("FAIL pixel x=%0d y=%0d: got 0x%0h, required 0x%0h",
                    m_shown % H_TOT, m_shown / H_TOT, act_v, exp_v);
   end

   // Hand-computed spot pixels: {x, y, RGB}.
   typedef struct { int x; int y; int rgb; } spot_t;
   spot_t spots [9] = '{'{150, 10, 'hFF0}, '{450, 10, 'hF0F}, '{750, 10, 'h000},
                        '{99, 299, 'hFFF}, '{100, 299, 'hFF0}, '{120, 400, 'h222},
                        '{799, 599, 'hFFF}, '{800, 0, 'h000}, '{0, 600, 'h000}};
   bit spot_hit [9];

   always @(negedge clk) begin
      for (int i = 0; i < 9; i++) begin
         if (m_valid && m_shown == spots[i].y * H_TOT + spots[i].x) begin
            check($sformatf("spot(%0d,%0d)", spots[i].x, spots[i].y),
                  32'({vr, vg, vb}), spots[i].rgb);
            spot_hit[i] = 1'b1;
         end
      end
   end

   // Sync pulse timing monitors.
   logic hs_d = 1'b0, vs_d = 1'b0;
   int vs_rises = 0;
   int vs_rgb_bad = 0;

   always @(negedge clk) begin
      if (hs && !hs_d) begin
         if (hs_rise < 0) check("hs_first_rise", rel, 857);
         else check("hs_period", rel - hs_rise, 1040);
         hs_rise = rel;
      end
      if (!hs && hs_d && hs_rise >= 0) check("hs_width", rel - hs_rise, 120);
      hs_d = hs;

      if (vs && ({vr, vg, vb} != 12'h000)) vs_rgb_bad++;
      if (vs && !vs_d) begin
         if (vs_rise < 0) check("vs_first_rise", rel, 637 * 1040 + 1);
         else check("vs_period", rel - vs_rise, FRAME);
         vs_rise = rel;
         vs_rises++;
      end
      if (!vs && vs_d && vs_rise >= 0) begin
         check("vs_width", rel - vs_rise, 6240);
         check("vs_rgb_zero", vs_rgb_bad, 0);
      end
      vs_d = vs;
   end

   initial begin
      bit reached;
      // Free-run from power-up without reset for a few clocks.
      repeat (3) @(negedge clk);

      // Start-up reset held for 5 clocks.
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_outputs", 32'({vr, vg, vb, hs, vs}), 0);
      rst = 1'b0;
      @(negedge clk);
      check("first_pixel_white", 32'({vr, vg, vb, hs, vs}), 'h3FFC);

      // Run to line 300, pixel 500, then reset mid-frame.
      reached = 1'b0;
      for (int i = 0; i < FRAME && !reached; i++) begin
         @(negedge clk);
         if (m_valid && m_shown == 300 * H_TOT + 500) reached = 1'b1;
      end
      check("reached_line300_px500", 32'(reached), 1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midreset_outputs", 32'({vr, vg, vb, hs, vs}), 0);
      rst = 1'b0;
      @(negedge clk);
      check("midreset_first_pixel", 32'({vr, vg, vb, hs, vs}), 'h3FFC);

      // Two full VS pulses after the mid-frame reset.
      for (int i = 0; i < 2 * FRAME + 1000 && vs_rises < 2; i++) @(negedge clk);
      check("vs_two_rises", vs_rises, 2);
      repeat (6300) @(negedge clk);

      for (int i = 0; i < 9; i++)
         check($sformatf("spot_seen(%0d,%0d)", spots[i].x, spots[i].y), 32'(spot_hit[i]), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
